// File: rtl/level_column_loader_if.sv
// ROM read port and block-grid load port of the level column loader.
interface level_column_loader_if #(
  parameter int ADDR_W   = 10,
  parameter int ID_W     = 3,
  parameter int NUM_ROWS = 10
);
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd;
  logic [ID_W-1:0]          mem_data;
  logic                     Shift;
  logic [NUM_ROWS*ID_W-1:0] new_block_id;

  modport master (output mem_addr, mem_rd, Shift, new_block_id, input mem_data);
  modport slave  (input mem_addr, mem_rd, Shift, new_block_id, output mem_data);
endinterface

// File: rtl/level_column_loader.sv
// Fetches level columns from ROM and hands them to the block grid as the
// per-frame scroll accumulator crosses each block boundary.
module level_column_loader #(
  parameter int NUM_ROWS   = 10,
  parameter int ID_W       = 3,
  parameter int BLOCK_PX   = 40,
  parameter int LEVEL_COLS = 64,
  parameter int START_COL  = 10,
  parameter int ADDR_W     = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic [2:0]            scroll_dx,
  level_column_loader_if.master bus,
  output logic                  ready,
  output logic                  at_end,
  output logic [5:0]            fine_x
);

  localparam int ROW_W = $clog2(NUM_ROWS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, FULL, SHIFT, DONE} state_t;

  state_t                   state, next_state;
  logic [ADDR_W-1:0]        col;
  logic [ROW_W-1:0]         row;
  logic                     pending;
  logic [NUM_ROWS*ID_W-1:0] col_buf;
  logic [6:0]               sum;
  logic                     tick_en;
  logic                     crossing;
  logic                     wr_en;
  logic [ROW_W-1:0]         wr_row;

  // Scrolling freezes while a crossing is still waiting to be shifted out.
  always_comb begin
    tick_en  = frame_tick && !pending && (state != DONE);
    sum      = {1'b0, fine_x} + {4'b0, scroll_dx};
    crossing = tick_en && (sum >= 7'(BLOCK_PX));
  end

  always_comb begin
    next_state   = state;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    bus.Shift    = 1'b0;
    ready        = 1'b0;
    at_end       = 1'b0;
    wr_en        = 1'b0;
    wr_row       = '0;
    case (state)
      IDLE: next_state = (START_COL >= LEVEL_COLS) ? DONE : FETCH;
      FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = ADDR_W'(32'(col) * NUM_ROWS + 32'(row));
        // Data arriving now belongs to the row requested one cycle earlier.
        wr_en        = (row != '0);
        wr_row       = row - 1'b1;
        if (row == ROW_W'(NUM_ROWS - 1))
          next_state = CAPTURE;
      end
      CAPTURE: begin
        wr_en      = 1'b1;
        wr_row     = ROW_W'(NUM_ROWS - 1);
        next_state = FULL;
      end
      FULL: begin
        ready = 1'b1;
        if (pending || crossing)
          next_state = SHIFT;
      end
      SHIFT: begin
        bus.Shift  = 1'b1;
        next_state = (col == ADDR_W'(LEVEL_COLS - 1)) ? DONE : FETCH;
      end
      DONE:    at_end = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  assign bus.new_block_id = col_buf;

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      col     <= ADDR_W'(START_COL);
      row     <= '0;
      pending <= 1'b0;
      fine_x  <= '0;
      col_buf <= '0;
    end else begin
      row <= (state == FETCH) ? row + 1'b1 : '0;
      if (wr_en)
        col_buf[ID_W*int'(wr_row) +: ID_W] <= bus.mem_data;
      if (state == SHIFT)
        col <= col + 1'b1;
      // A crossing outside FULL is remembered until the column is ready.
      if (crossing && state != FULL)
        pending <= 1'b1;
      else if (state == SHIFT)
        pending <= 1'b0;
      if (tick_en)
        fine_x <= crossing ? 6'(sum - 7'(BLOCK_PX)) : sum[5:0];
    end
  end

endmodule

// File: tb/tb_level_column_loader.sv
// Directed test of level_column_loader: a 64-column instance and a 12-column
// instance run side by side on the same stimulus against addr-mod-8 ROMs.
module tb_level_column_loader;

  localparam int NUM_ROWS = 10;
  localparam int ID_W     = 3;
  localparam int ADDR_W   = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] scroll_dx = 3'd0;
  logic       ready_a, at_end_a, ready_b, at_end_b;
  logic [5:0] fine_x_a, fine_x_b;

  int num_checks  = 0;
  int num_fail    = 0;
  int shift_cnt_a = 0;
  int shift_cnt_b = 0;

  always #5 Clk = ~Clk;

  level_column_loader_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_ROWS(NUM_ROWS)) bus_a ();
  level_column_loader_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_ROWS(NUM_ROWS)) bus_b ();

  level_column_loader dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .scroll_dx(scroll_dx),
    .bus(bus_a), .ready(ready_a), .at_end(at_end_a), .fine_x(fine_x_a)
  );

  level_column_loader #(.LEVEL_COLS(12)) dut_end (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .scroll_dx(scroll_dx),
    .bus(bus_b), .ready(ready_b), .at_end(at_end_b), .fine_x(fine_x_b)
  );

  // Level ROMs returning addr mod 8 one cycle after the read strobe.
  always @(posedge Clk) begin
    bus_a.mem_data <= bus_a.mem_addr[2:0];
    bus_b.mem_data <= bus_b.mem_addr[2:0];
    if (bus_a.Shift === 1'b1) shift_cnt_a <= shift_cnt_a + 1;
    if (bus_b.Shift === 1'b1) shift_cnt_b <= shift_cnt_b + 1;
  end

  function automatic logic [29:0] colWord(input int c);
    logic [29:0] w;
    w = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      w[3*r +: 3] = 3'((c * NUM_ROWS + r) % 8);
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic [2:0] dx);
    frame_tick = tick;
    scroll_dx  = dx;
    step(1);
    frame_tick = 1'b0;
    scroll_dx  = 3'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    Reset      = 1'b1;
    frame_tick = 1'b0;
    step(1);
    Reset = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rd"},     bus_a.mem_rd, 0);
    checkOutput({tag, "_addr"},   bus_a.mem_addr, 0);
    checkOutput({tag, "_shift"},  bus_a.Shift, 0);
    checkOutput({tag, "_nbid"},   bus_a.new_block_id, 0);
    checkOutput({tag, "_ready"},  ready_a, 0);
    checkOutput({tag, "_at_end"}, at_end_a, 0);
    checkOutput({tag, "_fine_x"}, fine_x_a, 0);
    checkOutput({tag, "_b_at_end"}, at_end_b, 0);
  endtask

  initial begin
    int ea[6];
    logic [29:0] w;

    // Reset release and first column fetch (addresses 100..109)
    step(1);
    doReset();
    checkIdleOutputs("rst");
    for (int k = 0; k < 10; k++) begin
      step(1);
      checkOutput($sformatf("fetch10_rd_%0d", k), bus_a.mem_rd, 1);
      checkOutput($sformatf("fetch10_addr_%0d", k), bus_a.mem_addr, 64'(100 + k));
    end
    step(1);
    checkOutput("capture_rd", bus_a.mem_rd, 0);
    checkOutput("capture_ready", ready_a, 0);
    step(1);
    checkOutput("full_ready", ready_a, 1);
    checkOutput("full_b_ready", ready_b, 1);
    checkOutput("col10_word", bus_a.new_block_id, colWord(10));
    w = bus_a.new_block_id;
    checkOutput("col10_row0", w[2:0], 4);
    checkOutput("col10_row3", w[11:9], 7);
    checkOutput("col10_row9", w[29:27], 5);

    // Six ticks of 7 px while FULL: the sixth crosses
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 3'd7);
      checkOutput($sformatf("scroll_fine_%0d", i), fine_x_a, 64'(7 * i));
      checkOutput($sformatf("scroll_noshift_%0d", i), bus_a.Shift, 0);
      checkOutput($sformatf("scroll_ready_%0d", i), ready_a, 1);
    end
    applyStimulus(1'b1, 3'd7);
    checkOutput("cross_shift", bus_a.Shift, 1);
    checkOutput("cross_ready", ready_a, 0);
    checkOutput("cross_fine", fine_x_a, 2);
    checkOutput("cross_b_shift", bus_b.Shift, 1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      checkOutput($sformatf("fetch11_addr_%0d", k), bus_a.mem_addr, 64'(110 + k));
      checkOutput($sformatf("fetch11_noshift_%0d", k), bus_a.Shift, 0);
    end
    step(2);
    checkOutput("col11_ready", ready_a, 1);
    checkOutput("col11_word", bus_a.new_block_id, colWord(11));
    checkOutput("shift_count_1", shift_cnt_a, 1);

    // Second crossing: the 12-column instance shifts its last column and ends
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 3'd7);
      checkOutput($sformatf("scroll2_fine_%0d", i), fine_x_a, 64'(2 + 7 * i));
    end
    applyStimulus(1'b1, 3'd7);
    checkOutput("cross2_shift", bus_a.Shift, 1);
    checkOutput("cross2_b_shift", bus_b.Shift, 1);
    checkOutput("cross2_fine", fine_x_a, 4);
    checkOutput("cross2_b_fine", fine_x_b, 4);

    // Crossing during the fetch of column 12 sets pending; DONE ignores ticks
    ea = '{11, 18, 25, 32, 39, 6};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'd7);
      checkOutput($sformatf("pend_fine_%0d", i), fine_x_a, 64'(ea[i]));
      checkOutput($sformatf("pend_noshift_%0d", i), bus_a.Shift, 0);
      checkOutput($sformatf("done_b_at_end_%0d", i), at_end_b, 1);
      checkOutput($sformatf("done_b_ready_%0d", i), ready_b, 0);
      checkOutput($sformatf("done_b_rd_%0d", i), bus_b.mem_rd, 0);
      checkOutput($sformatf("done_b_noshift_%0d", i), bus_b.Shift, 0);
      checkOutput($sformatf("done_b_fine_%0d", i), fine_x_b, 11);
    end
    applyStimulus(1'b1, 3'd7);
    checkOutput("pend_frozen_fine", fine_x_a, 6);
    checkOutput("done_frozen_b_fine", fine_x_b, 11);
    step(4);
    checkOutput("pend_capture_ready", ready_a, 0);
    step(1);
    checkOutput("pend_full_ready", ready_a, 1);
    checkOutput("pend_full_noshift", bus_a.Shift, 0);
    step(1);
    checkOutput("pend_shift", bus_a.Shift, 1);
    checkOutput("pend_shift_ready", ready_a, 0);
    step(1);
    checkOutput("pend_after_shift", bus_a.Shift, 0);
    checkOutput("fetch13_addr", bus_a.mem_addr, 130);
    checkOutput("shift_count_3", shift_cnt_a, 3);
    checkOutput("b_shift_count_2", shift_cnt_b, 2);

    // Reset in the middle of a fetch (row 5) clears everything
    doReset();
    applyStimulus(1'b1, 3'd5);
    applyStimulus(1'b1, 3'd5);
    applyStimulus(1'b1, 3'd5);
    checkOutput("pre_reset_fine", fine_x_a, 15);
    step(3);
    checkOutput("pre_reset_addr", bus_a.mem_addr, 105);
    doReset();
    checkIdleOutputs("midrst");
    step(1);
    checkOutput("refetch_addr_0", bus_a.mem_addr, 100);
    checkOutput("refetch_rd_0", bus_a.mem_rd, 1);
    step(9);
    checkOutput("refetch_addr_9", bus_a.mem_addr, 109);
    step(2);
    checkOutput("refetch_ready", ready_a, 1);
    checkOutput("refetch_word", bus_a.new_block_id, colWord(10));
    checkOutput("midrst_shift_count", shift_cnt_a, 3);

    // Zero scroll, then a sum of exactly 40
    applyStimulus(1'b1, 3'd0);
    checkOutput("dx0_fine", fine_x_a, 0);
    checkOutput("dx0_noshift", bus_a.Shift, 0);
    applyStimulus(1'b1, 3'd7);
    applyStimulus(1'b1, 3'd7);
    applyStimulus(1'b1, 3'd7);
    applyStimulus(1'b1, 3'd7);
    applyStimulus(1'b1, 3'd5);
    checkOutput("fine_33", fine_x_a, 33);
    applyStimulus(1'b1, 3'd0);
    checkOutput("dx0_hold_33", fine_x_a, 33);
    checkOutput("dx0_hold_ready", ready_a, 1);
    applyStimulus(1'b1, 3'd7);
    checkOutput("sum40_fine", fine_x_a, 0);
    checkOutput("sum40_shift", bus_a.Shift, 1);
    step(1);
    checkOutput("sum40_one_pulse", bus_a.Shift, 0);
    checkOutput("final_shift_count", shift_cnt_a, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
